// File: rtl/fifo_seq_reader.sv
// fifo_seq_reader: read-side traffic engine for an async FIFO pop port.
// Pops words in programmable bursts separated by idle gaps. Each popped word
// is checked against an incrementing golden sequence. The block counts reads
// and mismatches and captures the first mismatch. A watchdog aborts a run
// that sees too many consecutive empty cycles.
// Optional build macro: FIFO_SEQ_READER_RANDOM_STALL_EN adds an LFSR-driven
// random throttle on the pop request. It is disabled by default.
module fifo_seq_reader #(
    parameter int DATA_WIDTH     = 32,
    parameter int DATA_INCR      = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [31:0]           TOTAL,
    input  logic [7:0]            BURST_LEN,
    input  logic [7:0]            GAP_LEN,
    input  logic [DATA_WIDTH-1:0] SEED,
    output logic                  R_nEN,
    input  logic [DATA_WIDTH-1:0] R_DATA,
    input  logic                  R_EMPTY,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [31:0]           RD_COUNT,
    output logic [15:0]           ERR_COUNT,
    output logic                  ERR_FLAG,
    output logic [DATA_WIDTH-1:0] ERR_EXPECT,
    output logic [DATA_WIDTH-1:0] ERR_ACTUAL,
    output logic                  TIMEOUT
);

    localparam logic [DATA_WIDTH-1:0] INCR = DATA_WIDTH'(DATA_INCR);
    // The watchdog counter only has to reach TIMEOUT_CYCLES-1. It fires on
    // the empty cycle that would bring the count to TIMEOUT_CYCLES.
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [31:0]           r_remaining;
    logic [7:0]            r_burst_len;
    logic [7:0]            r_gap_len;
    logic [7:0]            r_burst_cnt;
    logic [7:0]            r_gap_cnt;
    logic [WD_W-1:0]       r_wd_cnt;
    logic [DATA_WIDTH-1:0] r_expect;
    logic [31:0]           r_rd_count;
    logic [15:0]           r_err_count;
    logic                  r_err_flag;
    logic [DATA_WIDTH-1:0] r_err_expect;
    logic [DATA_WIDTH-1:0] r_err_actual;
    logic                  r_timeout;

    logic                  w_start;
    logic                  w_stall;
    logic                  w_rd_active;
    logic                  w_pop;
    logic                  w_burst_end;
    logic                  w_wd_fire;

    assign w_start = (r_state == ST_IDLE) && START;

`ifdef FIFO_SEQ_READER_RANDOM_STALL_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_stall   = r_lfsr[0];

    // Free-running x^16+x^14+x^13+x^11+1 LFSR, reseeded on reset and at run launch.
    always_ff @(posedge CLK) begin
        if (RST || w_start) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
        end
    end
`else
    assign w_stall = 1'b0;
`endif

    // The pop request is decoded from the state register only. A stalled
    // READ cycle neither pops nor ticks the watchdog.
    assign w_rd_active = (r_state == ST_READ) && !w_stall;
    assign w_pop       = w_rd_active && !R_EMPTY;
    assign w_burst_end = (r_burst_len != 8'd0) && (r_burst_cnt == r_burst_len - 8'd1);
    assign w_wd_fire   = (TIMEOUT_CYCLES != 0) && w_rd_active && R_EMPTY
                         && (r_wd_cnt == WD_LAST);

    assign R_nEN      = !w_rd_active;
    assign BUSY       = (r_state != ST_IDLE);
    assign DONE       = (r_state == ST_FINISH);
    assign RD_COUNT   = r_rd_count;
    assign ERR_COUNT  = r_err_count;
    assign ERR_FLAG   = r_err_flag;
    assign ERR_EXPECT = r_err_expect;
    assign ERR_ACTUAL = r_err_actual;
    assign TIMEOUT    = r_timeout;

    // Next-state decode. The last pop of the run wins over entering GAP.
    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_next = (TOTAL != 32'd0) ? ST_READ : ST_FINISH;
                end
            end
            ST_READ: begin
                if (w_pop) begin
                    if (r_remaining == 32'd1) begin
                        w_next = ST_FINISH;
                    end else if (w_burst_end && (r_gap_len != 8'd0)) begin
                        w_next = ST_GAP;
                    end
                end else if (w_wd_fire) begin
                    w_next = ST_FINISH;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == r_gap_len - 8'd1) begin
                    w_next = ST_READ;
                end
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // State register. Reset mid-run drops straight back to IDLE without a DONE pulse.
    always_ff @(posedge CLK) begin
        // NOTE: clocked state uses non-blocking assignments so all registers update together.
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Run configuration, pop bookkeeping, data check, watchdog and gap timer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_remaining  <= '0;
            r_burst_len  <= '0;
            r_gap_len    <= '0;
            r_burst_cnt  <= '0;
            r_gap_cnt    <= '0;
            r_wd_cnt     <= '0;
            r_expect     <= '0;
            r_rd_count   <= '0;
            r_err_count  <= '0;
            r_err_flag   <= 1'b0;
            r_err_expect <= '0;
            r_err_actual <= '0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_start) begin
                r_remaining  <= TOTAL;
                r_burst_len  <= BURST_LEN;
                r_gap_len    <= GAP_LEN;
                r_burst_cnt  <= '0;
                r_expect     <= SEED;
                r_rd_count   <= '0;
                r_err_count  <= '0;
                r_err_flag   <= 1'b0;
                r_err_expect <= '0;
                r_err_actual <= '0;
                r_timeout    <= 1'b0;
            end

            if (w_pop) begin
                r_rd_count  <= r_rd_count + 32'd1;
                r_remaining <= r_remaining - 32'd1;
                // The golden value always advances. It never resyncs to R_DATA.
                r_expect    <= r_expect + INCR;
                r_burst_cnt <= w_burst_end ? 8'd0 : r_burst_cnt + 8'd1;
                if (R_DATA != r_expect) begin
                    if (r_err_count != 16'hFFFF) begin
                        r_err_count <= r_err_count + 16'd1;
                    end
                    if (!r_err_flag) begin
                        r_err_flag   <= 1'b1;
                        r_err_expect <= r_expect;
                        r_err_actual <= R_DATA;
                    end
                end
            end

            // The watchdog counts consecutive unstalled empty READ cycles.
            if (w_pop || (r_state != ST_READ)) begin
                r_wd_cnt <= '0;
            end else if (w_rd_active && R_EMPTY) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end

            if (w_wd_fire) begin
                r_timeout <= 1'b1;
            end

            if ((r_state == ST_GAP) && (w_next == ST_GAP)) begin
                r_gap_cnt <= r_gap_cnt + 8'd1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/fifo_seq_reader.md
Name: fifo_seq_reader

Overview:
- Read-side traffic engine for the FiFo_Async pop interface.
- Pops words in programmable bursts separated by idle gaps.
- Checks each popped word against an incrementing expected sequence; counts reads and mismatches and captures the first mismatch.
- Sits on the R_CLK side of an async FIFO DUT; it is the synthesizable consumer counterpart of the incrementing-data writer.

Parameters:
- DATA_WIDTH, 32, width of R_DATA and of the expected-value counter.
- DATA_INCR, 1, step added to the expected value after every pop.
- TIMEOUT_CYCLES, 1024, consecutive empty cycles in READ before the run is aborted; 0 disables the watchdog.

Ports:
- CLK  input  1  clock; all logic on posedge CLK.
- RST  input  1  synchronous reset, active-high.
- START  input  1  one-cycle pulse that launches a run; ignored unless in IDLE.
- TOTAL  input  32  number of words to pop in the run; sampled at START.
- BURST_LEN  input  8  pops per burst, sampled at START; 0 = single unbounded burst.
- GAP_LEN  input  8  idle cycles between bursts, sampled at START; 0 = no gap.
- SEED  input  DATA_WIDTH  first expected value, sampled at START.
- R_nEN  output  1  active-low pop request to the FIFO.
- R_DATA  input  DATA_WIDTH  FIFO head data, valid whenever R_EMPTY=0.
- R_EMPTY  input  1  FIFO empty.
- BUSY  output  1  high from the cycle after START until DONE.
- DONE  output  1  one-cycle completion pulse.
- RD_COUNT  output  32  pops completed in the current run.
- ERR_COUNT  output  16  mismatches, saturating at 16'hFFFF.
- ERR_FLAG  output  1  sticky; set on the first mismatch.
- ERR_EXPECT  output  DATA_WIDTH  expected value at the first mismatch.
- ERR_ACTUAL  output  DATA_WIDTH  R_DATA at the first mismatch.
- TIMEOUT  output  1  sticky; set when the watchdog fires.

Behaviour:
- Reset (RST=1 at posedge):
  - State goes to IDLE.
  - R_nEN=1, BUSY=0, DONE=0, TIMEOUT=0, ERR_FLAG=0.
  - RD_COUNT=0, ERR_COUNT=0, ERR_EXPECT=0, ERR_ACTUAL=0.
  - Internal counters clear.
  - Reset mid-run aborts immediately; no DONE pulse is generated.
- States:
  - IDLE -> READ on START with TOTAL!=0.
  - IDLE -> FINISH on START with TOTAL==0.
  - READ -> GAP when a pop completes the burst, GAP_LEN!=0 and words remain.
  - READ -> FINISH on the last pop, or on watchdog expiry.
  - GAP -> READ after GAP_LEN cycles in GAP.
  - FINISH -> IDLE after one cycle; DONE=1 during the FINISH cycle.
- START in IDLE:
  - Latches TOTAL, BURST_LEN, GAP_LEN; loads expected value = SEED.
  - Clears RD_COUNT, ERR_COUNT, ERR_FLAG, ERR_EXPECT, ERR_ACTUAL and TIMEOUT.
- Pop handshake:
  - R_nEN = ~(state==READ), decoded combinationally from the state register.
  - pop = (state==READ) & ~R_EMPTY; the FIFO dequeues on the same edge.
  - The data check happens on that edge: R_DATA is compared with the expected value.
  - Zero-latency check; one pop per cycle maximum.
- On pop:
  - RD_COUNT+1; remaining-1; expected += DATA_INCR (mod 2^DATA_WIDTH, wraps silently).
  - Burst counter +1.
- On mismatch:
  - ERR_COUNT+1, saturating.
  - If ERR_FLAG=0: capture ERR_EXPECT/ERR_ACTUAL and set ERR_FLAG.
  - The expected value still advances from the golden value (no resync to R_DATA).
- Burst boundary:
  - When the burst counter reaches BURST_LEN, it clears.
  - With GAP_LEN=0 or BURST_LEN=0, reading continues back-to-back.
  - The last pop of the run takes priority over entering GAP.
- Watchdog:
  - Counts consecutive READ cycles with R_EMPTY=1; resets on any pop or on leaving READ.
  - On reaching TIMEOUT_CYCLES: TIMEOUT=1, go to FINISH; RD_COUNT keeps its partial value.
- Empty while in READ:
  - R_nEN stays low; no pop, no counter change.
- Simultaneous events:
  - START while not IDLE is ignored.
  - A pop on the same cycle the watchdog would fire counts as a pop; the watchdog does not fire.

Optional Feature:
- Macro: FIFO_SEQ_READER_RANDOM_STALL_EN.
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset/START) advances every cycle.
  - When LFSR[0]=1 in READ, R_NEN is forced high for that cycle, giving a random throttle.
  - Stalled cycles neither pop nor advance the watchdog.
- Undefined:
  - No LFSR logic; R_nEN low for every READ cycle.

Test Plan:
- Basic run: FIFO prefilled with 0..7; START with TOTAL=8, BURST_LEN=0, GAP_LEN=0, SEED=0 -> 8 consecutive pops, DONE one cycle after the last pop, RD_COUNT=8, ERR_COUNT=0, ERR_FLAG=0.
- Burst/gap: TOTAL=6, BURST_LEN=2, GAP_LEN=3, FIFO always non-empty -> R_nEN low 2 cycles, high 3, repeated 3 times; no gap after the final burst; DONE at cycle 14.
- Corrupt data: stream 0,1,2,99,4; TOTAL=5, SEED=0 -> ERR_COUNT=1, ERR_EXPECT=3, ERR_ACTUAL=99; the next word 4 passes.
- Watchdog: TIMEOUT_CYCLES=16, TOTAL=4, FIFO supplies 2 words then stays empty -> TIMEOUT=1 after 16 empty cycles, RD_COUNT=2, DONE pulses once.
- Wrap and empty stall: DATA_WIDTH=8, SEED=8'hFE, TOTAL=4, R_EMPTY toggling every cycle -> pops only on non-empty cycles; expected sequence FE,FF,00,01; no errors.
- Reset mid-run: RST asserted after 3 of 10 pops -> next cycle IDLE, R_nEN=1, RD_COUNT=0, no DONE; a fresh START runs normally.
